// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Hit_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_next, busy_next;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              overflow;

  logic hit_data, hit_status;
  logic wr_data, wr_status;
  logic fifo_empty, fifo_full;
  logic push, pop;
  logic baud_last;
  logic unused_wdata;

  // Only the low byte of a store reaches the serial line.
  assign unused_wdata = ^Write_Data_i[31:8];

  assign hit_data   = (Address_i == BASE_ADDR);
  assign hit_status = (Address_i == STATUS_ADDR);
  assign Hit_o      = hit_data | hit_status;
  assign wr_data    = Mem_Write_i & hit_data;
  assign wr_status  = Mem_Write_i & hit_status;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // The FSM only takes a byte while idle; a pop frees a slot for a push on the same edge.
  assign pop  = (state == S_IDLE) & ~fifo_empty;
  assign push = wr_data & (~fifo_full | pop);

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // Load data is only driven during a load; STATUS = {empty, overflow, full, busy}.
  always_comb begin
    Read_Data_o = 32'b0;
    if (Mem_Read_i && hit_status)
      Read_Data_o = {28'b0, fifo_empty, overflow, fifo_full, busy_o};
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= Write_Data_i[7:0];
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_status)
        overflow <= 1'b0;
      else if (wr_data && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  // FSM state register together with the baud/bit datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      tx_o      <= tx_next;
      busy_o    <= busy_next;
    end
  end

  // Next-state logic: each of START, the 8 DATA bits and STOP holds for CLKS_PER_BIT cycles.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_next = S_START;
          baud_next  = '0;
          shift_next = fifo_mem[rd_ptr];
        end
      end
      S_START: begin
        if (baud_last) begin
          state_next   = S_DATA;
          baud_next    = '0;
          bit_idx_next = 3'd0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7)
            state_next = S_STOP;
          else
            bit_idx_next = bit_idx + 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          state_next = S_IDLE;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so tx_o changes on the same edge as the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE) || (count_next != '0);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam logic [31:0] TXDATA = 32'h1001_0000;
  localparam logic [31:0] STATUS = 32'h1001_0004;

  logic        clk;
  logic        reset;
  logic        Mem_Write_i;
  logic        Mem_Read_i;
  logic [31:0] Address_i;
  logic [31:0] Write_Data_i;
  logic [31:0] Read_Data_o;
  logic        Hit_o;
  logic        tx_o;
  logic        busy_o;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [9];
  int          pass_cnt;
  int          total_cnt;
  logic [8:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  logic        busy_at_end;
  logic        saw_low;
  logic [31:0] st;

  mmio_uart_tx #(
    .BASE_ADDR   (TXDATA),
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Mem_Write_i (Mem_Write_i),
    .Mem_Read_i  (Mem_Read_i),
    .Address_i   (Address_i),
    .Write_Data_i(Write_Data_i),
    .Read_Data_o (Read_Data_o),
    .Hit_o       (Hit_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    Mem_Write_i  = 1'b1;
    Address_i    = addr;
    Write_Data_i = data;
    @(negedge clk);
    Mem_Write_i  = 1'b0;
    Address_i    = 32'h0;
    Write_Data_i = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    Mem_Read_i = 1'b1;
    Address_i  = STATUS;
    #1;
    v          = Read_Data_o;
    Mem_Read_i = 1'b0;
    Address_i  = 32'h0;
  endtask

  // Called at the first negedge after the start bit begins; checks every cycle of the frame.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic exp_bit;
    for (int j = 0; j < 160; j++) begin
      if (j < 16)       exp_bit = 1'b0;
      else if (j < 144) exp_bit = b[(j - 16) / 16];
      else              exp_bit = 1'b1;
      chk1($sformatf("%s_tx_c%0d", tag, j), tx_o, exp_bit);
      if (j == 159) busy_at_end = busy_o;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_nframes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i),
          (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF,
          {23'b0, 1'b1, exp_q[i]});
  endtask

  // Independent receiver: samples mid-bit, records {framing_ok, byte}; abandons a frame on reset.
  initial begin : rx_monitor
    logic [7:0] b;
    logic       start_ok;
    logic       stop_ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx_o === 1'b0) begin
        aborted  = 1'b0;
        start_ok = 1'b0;
        stop_ok  = 1'b0;
        b        = 8'h0;
        for (int k = 1; k <= 152; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k == 8)
            start_ok = ~tx_o;
          else if (k >= 24 && k <= 136 && ((k - 24) % 16) == 0)
            b[(k - 24) / 16] = tx_o;
          else if (k == 152)
            stop_ok = tx_o;
        end
        if (!aborted) rx_q.push_back({start_ok & stop_ok, b});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset        = 1'b1;
    Mem_Write_i  = 1'b0;
    Mem_Read_i   = 1'b0;
    Address_i    = 32'h0;
    Write_Data_i = 32'h0;

    vecs[0] = '{1'b1, STATUS,        1'b1, 32'h8};
    vecs[1] = '{1'b0, STATUS,        1'b1, 32'h0};
    vecs[2] = '{1'b1, TXDATA,        1'b1, 32'h0};
    vecs[3] = '{1'b0, TXDATA,        1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h1001_0008, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h1001_0001, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h1001_0005, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h0001_0004, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 32'h9001_0004, 1'b0, 32'h0};

    repeat (3) @(negedge clk);
    chk1("reset_tx", tx_o, 1'b1);
    chk1("reset_busy", busy_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      Mem_Read_i = vecs[i].rd;
      Address_i  = vecs[i].addr;
      #1;
      chk1($sformatf("vec%0d_hit", i), Hit_o, vecs[i].hit);
      chk($sformatf("vec%0d_rdata", i), Read_Data_o, vecs[i].rdata);
      @(negedge clk);
    end
    Mem_Read_i = 1'b0;
    Address_i  = 32'h0;

    // Single byte, upper data bits must be ignored.
    rx_q.delete();
    do_write(TXDATA, 32'hABCD_EF55);
    chk1("single_tx_pre", tx_o, 1'b1);
    chk1("single_busy_rise", busy_o, 1'b1);
    @(negedge clk);
    expect_frame(8'h55, "single");
    chk1("single_busy_c160", busy_at_end, 1'b1);
    chk1("single_busy_c161", busy_o, 1'b0);
    chk1("single_tx_idle", tx_o, 1'b1);
    repeat (5) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'h55);
    check_rx("single");

    // Back-to-back frames with exactly one idle cycle between them.
    rx_q.delete();
    do_write(TXDATA, 32'hA5);
    do_write(TXDATA, 32'h3C);
    expect_frame(8'hA5, "b2b0");
    chk1("b2b_gap", tx_o, 1'b1);
    @(negedge clk);
    expect_frame(8'h3C, "b2b1");
    wait_idle(20, "b2b");
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check_rx("b2b");

    // Six consecutive writes: one in the shifter, four queued, the sixth dropped.
    rx_q.delete();
    for (int i = 1; i <= 6; i++) do_write(TXDATA, 32'(i * 17));
    read_status(st);
    chk("ovf_status", st, 32'h7);
    wait_idle(1000, "ovf");
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i * 17));
    check_rx("ovf");
    read_status(st);
    chk("ovf_status_idle", st, 32'hC);
    do_write(STATUS, 32'hFFFF_FFFF);
    read_status(st);
    chk("ovf_cleared", st, 32'h8);

    // Push into a full FIFO on the exact edge the FSM pops.
    rx_q.delete();
    for (int i = 0; i < 5; i++) do_write(TXDATA, 32'(161 + i));
    repeat (157) @(negedge clk);
    chk1("sim_tx_gap", tx_o, 1'b1);
    read_status(st);
    chk("sim_status_pre", st, 32'h3);
    do_write(TXDATA, 32'hA6);
    read_status(st);
    chk("sim_status_post", st, 32'h3);
    wait_idle(1200, "sim");
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(161 + i));
    check_rx("sim");

    // Address miss and an un-strobed access to TXDATA.
    rx_q.delete();
    Mem_Write_i  = 1'b1;
    Address_i    = 32'h1001_0008;
    Write_Data_i = 32'h41;
    #1;
    chk1("miss_hit", Hit_o, 1'b0);
    @(negedge clk);
    Mem_Write_i  = 1'b0;
    Address_i    = TXDATA;
    Write_Data_i = 32'h5A;
    #1;
    chk1("nostrobe_hit", Hit_o, 1'b1);
    chk("nostrobe_rdata", Read_Data_o, 32'h0);
    @(negedge clk);
    Address_i    = 32'h0;
    Write_Data_i = 32'h0;
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_o !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
    end
    chk1("miss_quiet", saw_low, 1'b0);
    chk1("miss_busy", busy_o, 1'b0);
    chk("miss_rx", 32'(rx_q.size()), 32'h0);
    read_status(st);
    chk("miss_status", st, 32'h8);

    // Reset in the middle of a low data bit.
    do_write(TXDATA, 32'hF0);
    repeat (20) @(negedge clk);
    chk1("mid_tx_low", tx_o, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk1("mid_tx_async", tx_o, 1'b1);
    chk1("mid_busy_async", busy_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_status(st);
    chk("mid_status", st, 32'h8);
    rx_q.delete();
    do_write(TXDATA, 32'hC3);
    @(negedge clk);
    expect_frame(8'hC3, "post");
    wait_idle(20, "post");
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'hC3);
    check_rx("post");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
